// File: rtl/nora_mem_pkg.sv
// rtl/nora_mem_pkg.sv - shared types and defaults for the NORA SRAM bus sequencer
package nora_mem_pkg;

  localparam int MEM_AW            = 21;
  localparam int MEM_STROBE_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } mem_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_AUX = 1'b1
  } mem_owner_t;

endpackage

// File: rtl/mem_strobe_timer.sv
// rtl/mem_strobe_timer.sv - down-counter that marks the last cycle of the SRAM strobe
module mem_strobe_timer #(
  parameter int CYCLES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  output logic last
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt;

  // Loaded during SETUP so the first STROBE cycle already sees the full count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - CPU/AUX sequencer and arbiter for the external SRAM bus
module sram_bus_arbiter
  import nora_mem_pkg::*;
#(
  parameter int AW            = MEM_AW,
  parameter int STROBE_CYCLES = MEM_STROBE_CYCLES
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_rwn,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_done,
  input  logic          cpu_window,
  input  logic          aux_req,
  input  logic [AW-1:0] aux_addr,
  input  logic          aux_rwn,
  input  logic [7:0]    aux_wdata,
  output logic [7:0]    aux_rdata,
  output logic          aux_ack,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_wdata_oe,
  input  logic [7:0]    mem_rdata,
  output logic          mem_csn,
  output logic          mem_rdn,
  output logic          mem_wrn,
  output logic          cpu_overrun
);

  mem_state_t    state;
  mem_owner_t    owner;
  logic          cur_rwn;
  logic          cpu_pend;
  logic          strobe_last;
  logic          timer_load;
  logic          cpu_go;
  logic          aux_go;
  logic [AW-1:0] sel_addr;
  logic [7:0]    sel_wdata;
  logic          sel_rwn;

  assign timer_load = (state == ST_SETUP);

  mem_strobe_timer #(
    .CYCLES (STROBE_CYCLES)
  ) u_strobe_timer (
    .clk    (clk),
    .resetn (resetn),
    .load   (timer_load),
    .last   (strobe_last)
  );

  // The AUX requester keeps aux_req high through its own ack cycle, so it
  // must not requalify out of its own HOLD.
  always_comb begin
    cpu_go = 1'b0;
    aux_go = 1'b0;
    if (state == ST_IDLE || state == ST_HOLD) begin
      cpu_go = cpu_req || cpu_pend;
      aux_go = !cpu_go && aux_req && !cpu_window &&
               !(state == ST_HOLD && owner == OWN_AUX);
    end
  end

  assign sel_addr  = cpu_go ? cpu_addr  : aux_addr;
  assign sel_wdata = cpu_go ? cpu_wdata : aux_wdata;
  assign sel_rwn   = cpu_go ? cpu_rwn   : aux_rwn;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      owner        <= OWN_CPU;
      cur_rwn      <= 1'b1;
      cpu_pend     <= 1'b0;
      cpu_overrun  <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wdata_oe <= 1'b0;
      mem_csn      <= 1'b1;
      mem_rdn      <= 1'b1;
      mem_wrn      <= 1'b1;
      cpu_rdata    <= '0;
      aux_rdata    <= '0;
      cpu_done     <= 1'b0;
      aux_ack      <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      aux_ack  <= 1'b0;

      if (cpu_req && cpu_pend) begin
        cpu_overrun <= 1'b1;
      end
      if (cpu_go) begin
        cpu_pend <= 1'b0;
      end else if (cpu_req && (state == ST_SETUP || state == ST_STROBE)) begin
        cpu_pend <= 1'b1;
      end

      case (state)
        ST_IDLE, ST_HOLD: begin
          if (cpu_go || aux_go) begin
            state        <= ST_SETUP;
            owner        <= cpu_go ? OWN_CPU : OWN_AUX;
            mem_addr     <= sel_addr;
            mem_wdata    <= sel_wdata;
            cur_rwn      <= sel_rwn;
            mem_wdata_oe <= !sel_rwn;
            mem_csn      <= 1'b0;
          end else begin
            state        <= ST_IDLE;
            mem_wdata_oe <= 1'b0;
            mem_csn      <= 1'b1;
          end
        end
        ST_SETUP: begin
          state   <= ST_STROBE;
          mem_rdn <= !cur_rwn;
          mem_wrn <= cur_rwn;
        end
        ST_STROBE: begin
          if (strobe_last) begin
            state   <= ST_HOLD;
            mem_rdn <= 1'b1;
            mem_wrn <= 1'b1;
            if (owner == OWN_CPU) begin
              cpu_done <= 1'b1;
              if (cur_rwn) cpu_rdata <= mem_rdata;
            end else begin
              aux_ack <= 1'b1;
              if (cur_rwn) aux_rdata <= mem_rdata;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - scoreboard bench for sram_bus_arbiter
module tb_sram_bus_arbiter;

  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_rwn;
  logic [7:0]    cpu_wdata;
  logic [7:0]    cpu_rdata;
  logic          cpu_done;
  logic          cpu_window;
  logic          aux_req;
  logic [AW-1:0] aux_addr;
  logic          aux_rwn;
  logic [7:0]    aux_wdata;
  logic [7:0]    aux_rdata;
  logic          aux_ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_wdata_oe;
  logic [7:0]    mem_rdata = 8'hEE;
  logic          mem_csn;
  logic          mem_rdn;
  logic          mem_wrn;
  logic          cpu_overrun;

  sram_bus_arbiter #(
    .AW            (AW),
    .STROBE_CYCLES (2)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cpu_req      (cpu_req),
    .cpu_addr     (cpu_addr),
    .cpu_rwn      (cpu_rwn),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_done     (cpu_done),
    .cpu_window   (cpu_window),
    .aux_req      (aux_req),
    .aux_addr     (aux_addr),
    .aux_rwn      (aux_rwn),
    .aux_wdata    (aux_wdata),
    .aux_rdata    (aux_rdata),
    .aux_ack      (aux_ack),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wdata_oe (mem_wdata_oe),
    .mem_rdata    (mem_rdata),
    .mem_csn      (mem_csn),
    .mem_rdn      (mem_rdn),
    .mem_wrn      (mem_wrn),
    .cpu_overrun  (cpu_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    bit         rd;
    logic [7:0] data;
  } exp_t;

  exp_t       cpu_q[$];
  exp_t       aux_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         done_seen = 0;
  int         ack_seen = 0;
  int         csn_low;
  int         d0;
  int         a0;
  logic [7:0] mem_model [logic [AW-1:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM model
  always @(negedge clk) begin
    if (!mem_csn && !mem_wrn && mem_wdata_oe) mem_model[mem_addr] = mem_wdata;
    if (!mem_csn && !mem_rdn)
      mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 8'h00;
    else
      mem_rdata = 8'hEE;
  end

  // Monitor: retire expected completions as the DUT presents them
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      wr_cnt = 0;
      rd_cnt = 0;
    end else begin
      if (!mem_wrn) wr_cnt++;
      if (!mem_rdn) rd_cnt++;
      if (cpu_done) begin
        done_seen++;
        if (cpu_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cpu_done_unexpected: pulse at cycle %0d, none expected", cyc);
        end else begin
          e = cpu_q.pop_front();
          chk("cpu_done_cycle", cyc, e.due);
          if (e.rd) chk("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, e.data});
          chk("cpu_wr_strobe_len", wr_cnt, e.rd ? 0 : 2);
          chk("cpu_rd_strobe_len", rd_cnt, e.rd ? 2 : 0);
        end
        wr_cnt = 0;
        rd_cnt = 0;
      end
      if (aux_ack) begin
        ack_seen++;
        if (aux_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL aux_ack_unexpected: pulse at cycle %0d, none expected", cyc);
        end else begin
          e = aux_q.pop_front();
          chk("aux_ack_cycle", cyc, e.due);
          if (e.rd) chk("aux_rdata", {24'h0, aux_rdata}, {24'h0, e.data});
          chk("aux_wr_strobe_len", wr_cnt, e.rd ? 0 : 2);
          chk("aux_rd_strobe_len", rd_cnt, e.rd ? 2 : 0);
        end
        wr_cnt = 0;
        rd_cnt = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_pulse(input logic [AW-1:0] a, input logic rwn, input logic [7:0] wd);
    cpu_addr  = a;
    cpu_rwn   = rwn;
    cpu_wdata = wd;
    cpu_req   = 1'b1;
    tick(1);
    cpu_req   = 1'b0;
  endtask

  task automatic cpu_issue(input logic [AW-1:0] a, input logic rwn, input logic [7:0] wd,
                           input logic [7:0] rd_exp, input int lat);
    cpu_q.push_back('{cyc + lat, rwn, rd_exp});
    cpu_pulse(a, rwn, wd);
  endtask

  task automatic aux_start(input logic [AW-1:0] a, input logic rwn, input logic [7:0] wd,
                           input logic [7:0] rd_exp, input int lat);
    aux_q.push_back('{cyc + lat, rwn, rd_exp});
    aux_addr  = a;
    aux_rwn   = rwn;
    aux_wdata = wd;
    aux_req   = 1'b1;
  endtask

  task automatic aux_wait_ack();
    int n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (aux_ack) break;
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL aux_ack_timeout: no ack within 60 cycles (cycle %0d)", cyc);
    end
    @(posedge clk);
    #1;
    aux_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((cpu_q.size() != 0 || aux_q.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cpu_q.size() != 0 || aux_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout: cpu pending %0d, aux pending %0d", cpu_q.size(), aux_q.size());
      cpu_q.delete();
      aux_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn     = 1'b0;
    cpu_req    = 1'b0;
    cpu_addr   = '0;
    cpu_rwn    = 1'b1;
    cpu_wdata  = 8'h00;
    cpu_window = 1'b0;
    aux_req    = 1'b0;
    aux_addr   = '0;
    aux_rwn    = 1'b1;
    aux_wdata  = 8'h00;
    mem_model[21'h1FFFFF] = 8'h3C;
    tick(3);

    chk("rst_csn", mem_csn, 1);
    chk("rst_rdn", mem_rdn, 1);
    chk("rst_wrn", mem_wrn, 1);
    chk("rst_oe", mem_wdata_oe, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_aux_rdata", aux_rdata, 0);
    chk("rst_done", cpu_done, 0);
    chk("rst_ack", aux_ack, 0);
    chk("rst_overrun", cpu_overrun, 0);
    resetn = 1'b1;
    tick(2);

    // CPU write then read-back
    cpu_issue(21'h012345, 1'b0, 8'hA5, 8'h00, 4);
    wait_idle();
    chk("idle_csn", mem_csn, 1);
    chk("idle_oe", mem_wdata_oe, 0);
    chk("idle_addr_held", mem_addr, 21'h012345);
    cpu_issue(21'h012345, 1'b1, 8'h00, 8'hA5, 4);
    wait_idle();

    // AUX read at the top of the address space
    aux_start(21'h1FFFFF, 1'b1, 8'h00, 8'h3C, 4);
    aux_wait_ack();
    wait_idle();

    // Simultaneous requests: CPU write first, AUX read of the same byte back-to-back
    cpu_q.push_back('{cyc + 4, 1'b0, 8'h00});
    aux_q.push_back('{cyc + 8, 1'b1, 8'h5A});
    aux_addr = 21'h000777;
    aux_rwn  = 1'b1;
    aux_req  = 1'b1;
    cpu_pulse(21'h000777, 1'b0, 8'h5A);
    aux_wait_ack();
    wait_idle();

    // AUX write held off by cpu_window for 20 cycles
    cpu_window = 1'b1;
    aux_start(21'h0ABCDE, 1'b0, 8'hC3, 8'h00, 24);
    csn_low = 0;
    repeat (20) begin
      @(negedge clk);
      if (!mem_csn) csn_low++;
      @(posedge clk);
      #1;
    end
    chk("aux_blocked_csn_low_cycles", csn_low, 0);
    cpu_window = 1'b0;
    aux_wait_ack();
    wait_idle();

    // Collision: CPU request one cycle after AUX SETUP
    aux_start(21'h0ABCDE, 1'b1, 8'h00, 8'hC3, 4);
    tick(2);
    cpu_issue(21'h1FFFFF, 1'b1, 8'h00, 8'h3C, 6);
    aux_wait_ack();
    wait_idle();
    chk("overrun_clear_before", cpu_overrun, 0);

    // Overrun: two CPU pulses during one AUX transaction
    d0 = done_seen;
    aux_start(21'h000777, 1'b1, 8'h00, 8'h5A, 4);
    tick(2);
    cpu_issue(21'h012345, 1'b1, 8'h00, 8'hA5, 6);
    cpu_pulse(21'h012345, 1'b1, 8'h00);
    aux_wait_ack();
    wait_idle();
    tick(6);
    chk("cpu_overrun_set", cpu_overrun, 1);
    chk("overrun_single_txn", done_seen - d0, 1);

    // Reset in the middle of a write strobe
    d0 = done_seen;
    a0 = ack_seen;
    cpu_pulse(21'h012345, 1'b0, 8'hFF);
    tick(1);
    #2;
    chk("abort_wrn_low_before", mem_wrn, 0);
    resetn = 1'b0;
    #1;
    chk("abort_wrn", mem_wrn, 1);
    chk("abort_csn", mem_csn, 1);
    chk("abort_oe", mem_wdata_oe, 0);
    chk("abort_overrun_cleared", cpu_overrun, 0);
    tick(2);
    resetn = 1'b1;
    tick(10);
    chk("abort_no_done", done_seen - d0, 0);
    chk("abort_no_ack", ack_seen - a0, 0);

    // Recovery after reset
    cpu_issue(21'h1FFFFF, 1'b1, 8'h00, 8'h3C, 4);
    wait_idle();
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
